// File: rtl/angstrom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : angstrom_pkg
// Description : Constants shared by the port bridge and its FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package angstrom_pkg;

    // Every byte that crosses the bridge is this wide.
    localparam int c_DATA_W        = 8;
    // Queue depth per direction when the top parameter is left at its default.
    localparam int c_DEPTH_DEFAULT = 4;

endpackage : angstrom_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a valid/ready push side and a
//               valid/ready pop side. The head is shown combinationally and
//               reads as zero while the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import angstrom_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int WIDTH = c_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic             full,
    output logic             empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_push;
    logic               w_pop;

    assign full       = (r_count == c_FULL_COUNT);
    assign empty      = (r_count == '0);
    assign pop_valid  = !empty;
    assign pop_data   = empty ? '0 : r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a full queue can still take a
    // push; the ready output reflects that so the pushing side never loses
    // a byte it believes was accepted.
    assign w_pop      = pop_ready && !empty;
    assign push_ready = !full || w_pop;
    assign w_push     = push_valid && push_ready;

    // Storage is written only on an accepted push and is never cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : port_bridge
// Description : Byte bridge between a host stream interface and a CPU's
//               INP/OUT ports, one FIFO per direction.
//               Optional macro PORT_BRIDGE_ERR_EN adds sticky overflow /
//               underflow flags with a synchronous clear input.
// Revision    : 1.0 - initial release
// ============================================================================
module port_bridge
    import angstrom_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [c_DATA_W-1:0] host_tx_data_i,
    input  logic                host_tx_valid_i,
    output logic                host_tx_ready_o,
    output logic [c_DATA_W-1:0] cpu_inp_o,
    input  logic                cpu_inp_rd_i,
    input  logic [c_DATA_W-1:0] cpu_out_i,
    input  logic                cpu_out_wr_i,
    output logic [c_DATA_W-1:0] host_rx_data_o,
    output logic                host_rx_valid_o,
    input  logic                host_rx_ready_i,
    output logic                inp_empty_o
`ifdef PORT_BRIDGE_ERR_EN
    ,
    input  logic                err_clr_i,
    output logic                ovf_o,
    output logic                unf_o
`endif
);

    logic w_inp_pop_valid;
    logic w_inp_full;
    logic w_inp_empty;
    logic w_out_push_ready;
    logic w_out_full;
    logic w_out_empty;

    assign inp_empty_o = w_inp_empty;

    // Host -> CPU: the CPU reads the head on the same edge it pops it.
    sync_fifo #(
        .DEPTH      (DEPTH),
        .WIDTH      (c_DATA_W)
    ) u_inbound (
        .clk        (clk_i),
        .rst        (rst_i),
        .push_data  (host_tx_data_i),
        .push_valid (host_tx_valid_i),
        .push_ready (host_tx_ready_o),
        .pop_data   (cpu_inp_o),
        .pop_valid  (w_inp_pop_valid),
        .pop_ready  (cpu_inp_rd_i),
        .full       (w_inp_full),
        .empty      (w_inp_empty)
    );

    // CPU -> host: an OUT that finds no room is simply not accepted (dropped).
    sync_fifo #(
        .DEPTH      (DEPTH),
        .WIDTH      (c_DATA_W)
    ) u_outbound (
        .clk        (clk_i),
        .rst        (rst_i),
        .push_data  (cpu_out_i),
        .push_valid (cpu_out_wr_i),
        .push_ready (w_out_push_ready),
        .pop_data   (host_rx_data_o),
        .pop_valid  (host_rx_valid_o),
        .pop_ready  (host_rx_ready_i),
        .full       (w_out_full),
        .empty      (w_out_empty)
    );

    // Status lines not needed by the bridge itself.
    logic w_unused_status;
    assign w_unused_status = &{1'b0, w_inp_pop_valid, w_inp_full,
                               w_out_full, w_out_empty, w_out_push_ready};

`ifdef PORT_BRIDGE_ERR_EN
    logic r_ovf;
    logic r_unf;
    logic w_drop;
    logic w_underflow;

    assign w_drop      = cpu_out_wr_i && !w_out_push_ready;
    assign w_underflow = cpu_inp_rd_i && w_inp_empty;
    assign ovf_o       = r_ovf;
    assign unf_o       = r_unf;

    // Sticky error flags; a clear in the same cycle beats a new event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (err_clr_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_drop;
            r_unf <= r_unf | w_underflow;
        end
    end
`else
    // Without error reporting, drops and empty reads leave no trace.
`endif

endmodule : port_bridge
`default_nettype wire

// File: tb/tb_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_bridge
// Description : Self-checking bench for port_bridge: directed vector table,
//               hand-written corner sequences and a randomized run against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] host_tx_data = 8'h00;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] cpu_inp;
    logic       cpu_inp_rd = 1'b0;
    logic [7:0] cpu_out = 8'h00;
    logic       cpu_out_wr = 1'b0;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready = 1'b0;
    logic       inp_empty;
`ifdef PORT_BRIDGE_ERR_EN
    logic       err_clr = 1'b0;
    logic       ovf;
    logic       unf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    port_bridge #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .host_tx_data_i  (host_tx_data),
        .host_tx_valid_i (host_tx_valid),
        .host_tx_ready_o (host_tx_ready),
        .cpu_inp_o       (cpu_inp),
        .cpu_inp_rd_i    (cpu_inp_rd),
        .cpu_out_i       (cpu_out),
        .cpu_out_wr_i    (cpu_out_wr),
        .host_rx_data_o  (host_rx_data),
        .host_rx_valid_o (host_rx_valid),
        .host_rx_ready_i (host_rx_ready),
        .inp_empty_o     (inp_empty)
`ifdef PORT_BRIDGE_ERR_EN
        ,
        .err_clr_i       (err_clr),
        .ovf_o           (ovf),
        .unf_o           (unf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        host_tx_valid = 1'b0;
        cpu_inp_rd    = 1'b0;
        cpu_out_wr    = 1'b0;
        host_rx_ready = 1'b0;
`ifdef PORT_BRIDGE_ERR_EN
        err_clr       = 1'b0;
`endif
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, ".tx_ready"},  {7'b0, host_tx_ready}, 8'h01);
        check({tag, ".cpu_inp"},   cpu_inp,               8'h00);
        check({tag, ".inp_empty"}, {7'b0, inp_empty},     8'h01);
        check({tag, ".rx_valid"},  {7'b0, host_rx_valid}, 8'h00);
    endtask

    // One clock: inputs applied on the falling edge, held across the rising
    // edge, then returned to idle before outputs are sampled.
    task automatic step(input logic hv, input logic [7:0] hd, input logic rd,
                        input logic wr, input logic [7:0] od, input logic rr);
        @(negedge clk);
        host_tx_valid = hv; host_tx_data = hd; cpu_inp_rd = rd;
        cpu_out_wr = wr; cpu_out = od; host_rx_ready = rr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    typedef struct {
        logic       hv;
        logic [7:0] hd;
        logic       rd;
        logic       wr;
        logic [7:0] od;
        logic       rr;
        logic       e_txr;
        logic [7:0] e_inp;
        logic       e_empty;
        logic       e_rxv;
        logic [7:0] e_rxd;
    } vec_t;

    vec_t vecs[16];

    // Reference model state for the randomized run.
    logic [7:0] inq[$];
    logic [7:0] outq[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] exp_head;
        logic       in_pop, out_pop, in_acc, out_acc;
        logic [7:0] drained[$];
        logic [7:0] want[4];

        //            hv  hd    rd  wr  od    rr  txr inp   emp rxv rxd
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};

        // Reset state while reset is held.
        #2;
        check_idle_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].hv, vecs[i].hd, vecs[i].rd, vecs[i].wr, vecs[i].od, vecs[i].rr);
            check($sformatf("vec%0d.tx_ready", i),  {7'b0, host_tx_ready}, {7'b0, vecs[i].e_txr});
            check($sformatf("vec%0d.cpu_inp", i),   cpu_inp,               vecs[i].e_inp);
            check($sformatf("vec%0d.inp_empty", i), {7'b0, inp_empty},     {7'b0, vecs[i].e_empty});
            check($sformatf("vec%0d.rx_valid", i),  {7'b0, host_rx_valid}, {7'b0, vecs[i].e_rxv});
            check($sformatf("vec%0d.rx_data", i),   host_rx_data,          vecs[i].e_rxd);
        end

        // Outbound full, OUT coincident with a host pop, then OUT while full.
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
        check("full.rx_head", host_rx_data, 8'h10);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h14, 1'b1);
        check("popfull.rx_head", host_rx_data, 8'h11);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0);
        want = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.valid", i), {7'b0, host_rx_valid}, 8'h01);
            check($sformatf("drain%0d.data", i),  host_rx_data,          want[i]);
            step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("drained.valid", {7'b0, host_rx_valid}, 8'h00);

`ifdef PORT_BRIDGE_ERR_EN
        check("err.ovf_init", {7'b0, ovf}, 8'h00);
        check("err.unf_init", {7'b0, unf}, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
        check("err.ovf_before", {7'b0, ovf}, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h24, 1'b0);
        check("err.ovf_set", {7'b0, ovf}, 8'h01);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("err.ovf_sticky", {7'b0, ovf}, 8'h01);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        check("err.unf_set", {7'b0, unf}, 8'h01);
        @(negedge clk); err_clr = 1'b1; cpu_inp_rd = 1'b1;
        @(posedge clk); #1; idle_inputs();
        check("err.ovf_clr", {7'b0, ovf}, 8'h00);
        check("err.unf_clr_wins", {7'b0, unf}, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // Asynchronous reset with bytes queued in both directions.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
        check("prerst.cpu_inp", cpu_inp, 8'h60);
        check("prerst.rx_valid", {7'b0, host_rx_valid}, 8'h01);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_reset_values("asyncrst");
        check("asyncrst.rx_data", host_rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against a queue model; phases bias fill/drain.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit push_heavy;
            push_heavy = ((cyc / 150) % 2) == 0;
            @(negedge clk);
            host_tx_valid = push_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            host_tx_data  = 8'($urandom);
            cpu_inp_rd    = push_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cpu_out_wr    = push_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cpu_out       = 8'($urandom);
            host_rx_ready = push_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            in_pop  = cpu_inp_rd && (inq.size() > 0);
            out_pop = host_rx_ready && (outq.size() > 0);
            in_acc  = host_tx_valid && ((inq.size() < DEPTH) || in_pop);
            out_acc = cpu_out_wr && ((outq.size() < DEPTH) || out_pop);
            exp_head = (inq.size() > 0) ? inq[0] : 8'h00;
            check("rnd.cpu_inp",   cpu_inp,               exp_head);
            check("rnd.inp_empty", {7'b0, inp_empty},     {7'b0, inq.size() == 0});
            check("rnd.tx_ready",  {7'b0, host_tx_ready}, {7'b0, (inq.size() < DEPTH) || in_pop});
            exp_head = (outq.size() > 0) ? outq[0] : 8'h00;
            check("rnd.rx_data",   host_rx_data,          exp_head);
            check("rnd.rx_valid",  {7'b0, host_rx_valid}, {7'b0, outq.size() > 0});
            @(posedge clk);
            if (in_pop)  void'(inq.pop_front());
            if (out_pop) begin
                drained.push_back(outq[0]);
                void'(outq.pop_front());
            end
            if (in_acc)  inq.push_back(host_tx_data);
            if (out_acc) outq.push_back(cpu_out);
        end
        @(negedge clk);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_port_bridge
`default_nettype wire
